prf_wb_arbiter: RTL and testbench

Shares the physical register file's write ports among the execution units that produce results: ALU, branch (JAL/JALR link value) and LSU (load data). Each requester gets a small FIFO with a valid/ready handshake. Each cycle a rotating-priority arbiter grants up to two FIFO heads onto two registered write ports. The write ports drive the PRF write ports and the busy-table wakeup broadcast.

---
 rtl/prf_wb_arbiter_pkg.sv | 27 ++
 rtl/prf_wb_arbiter_if.sv | 50 +++++
 rtl/prf_wb_arbiter_fifo.sv | 54 +++++
 rtl/prf_wb_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_prf_wb_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/prf_wb_arbiter_pkg.sv
// prf_wb_pkg: shared types and constants for the PRF write-back arbiter.
//   NUM_REQ / REQ_*  : requester count and index order (ALU, BR, LSU)
//   wb_req_t         : buffered write-back payload {dest, data} at the
//                      default 7-bit preg / 32-bit data widths
//   req_idx_inc()    : increment of a requester index, wrapping mod NUM_REQ
package prf_wb_pkg;

  localparam int NUM_REQ = 3;
  localparam int REQ_ALU = 0;
  localparam int REQ_BR  = 1;
  localparam int REQ_LSU = 2;

  localparam int WB_DATA_WIDTH = 32;
  localparam int WB_PREG_WIDTH = 7;

  typedef struct packed {
    logic [WB_PREG_WIDTH-1:0] dest;
    logic [WB_DATA_WIDTH-1:0] data;
  } wb_req_t;

  typedef logic [1:0] req_idx_t;

  function automatic req_idx_t req_idx_inc(input req_idx_t idx);
    return (idx == req_idx_t'(NUM_REQ - 1)) ? req_idx_t'(0) : idx + req_idx_t'(1);
  endfunction

endpackage

// File: rtl/prf_wb_arbiter_if.sv
// prf_wb_if: bundles the three requester handshakes and the two write ports.
//   x_valid/x_dest/x_data : result offered by requester x (alu, br, lsu)
//   x_ready               : requester FIFO can accept this cycle
//   wbN_valid/dest/data   : registered PRF write port N (N = 0, 1)
// Modports: master = producer/consumer side, slave = the arbiter.
interface prf_wb_if #(
  parameter int DATA_WIDTH = 32,
  parameter int PREG_WIDTH = 7
);
  logic                  alu_valid;
  logic                  alu_ready;
  logic [PREG_WIDTH-1:0] alu_dest;
  logic [DATA_WIDTH-1:0] alu_data;

  logic                  br_valid;
  logic                  br_ready;
  logic [PREG_WIDTH-1:0] br_dest;
  logic [DATA_WIDTH-1:0] br_data;

  logic                  lsu_valid;
  logic                  lsu_ready;
  logic [PREG_WIDTH-1:0] lsu_dest;
  logic [DATA_WIDTH-1:0] lsu_data;

  logic                  wb0_valid;
  logic [PREG_WIDTH-1:0] wb0_dest;
  logic [DATA_WIDTH-1:0] wb0_data;

  logic                  wb1_valid;
  logic [PREG_WIDTH-1:0] wb1_dest;
  logic [DATA_WIDTH-1:0] wb1_data;

  modport master (
    output alu_valid, alu_dest, alu_data,
    output br_valid,  br_dest,  br_data,
    output lsu_valid, lsu_dest, lsu_data,
    input  alu_ready, br_ready, lsu_ready,
    input  wb0_valid, wb0_dest, wb0_data,
    input  wb1_valid, wb1_dest, wb1_data
  );

  modport slave (
    input  alu_valid, alu_dest, alu_data,
    input  br_valid,  br_dest,  br_data,
    input  lsu_valid, lsu_dest, lsu_data,
    output alu_ready, br_ready, lsu_ready,
    output wb0_valid, wb0_dest, wb0_data,
    output wb1_valid, wb1_dest, wb1_data
  );
endinterface

// File: rtl/prf_wb_arbiter_fifo.sv
// wb_req_fifo: small show-ahead FIFO holding pending write-back results.
//   clk, reset : clock, synchronous active-high reset
//   clear      : drop all entries (mispredict flush)
//   push/push_data : enqueue (caller guarantees !full)
//   pop        : dequeue head (caller guarantees !empty)
//   head       : current head entry, valid while !empty
//   full/empty : occupancy status
// Pointers carry one extra wrap bit so full and empty are distinguishable
// without a separate counter.
module wb_req_fifo
  import prf_wb_pkg::*;
#(
  parameter int  DEPTH = 2,
  parameter type T     = wb_req_t
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic push,
  input  T     push_data,
  input  logic pop,
  output T     head,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr_reg;
  logic [AW:0] rd_ptr_reg;
  T            mem [DEPTH];

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + {{AW{1'b0}}, 1'b1};
      if (pop)  rd_ptr_reg <= rd_ptr_reg + {{AW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg[AW-1:0]] <= push_data;
  end

  // The arbiter needs the head in the same cycle, so the read is
  // asynchronous; at these depths the array maps to distributed storage.
  assign head  = mem[rd_ptr_reg[AW-1:0]];
  assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                 (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign empty = (wr_ptr_reg == rd_ptr_reg);

endmodule

// File: rtl/prf_wb_arbiter.sv
// prf_wb_arbiter: shares two PRF write ports among ALU, BR and LSU results.
//   clk, reset : clock, synchronous active-high reset
//   flush      : mispredict flush, drops all buffered results
//   bus        : prf_wb_if.slave -- three valid/ready requesters and the
//                two registered write ports wb0/wb1
// Optional (macro PRF_WB_ARB_STALL_CNT_EN):
//   alu_stall_cnt, br_stall_cnt, lsu_stall_cnt : saturating 32-bit counts of
//   cycles a requester was valid but its FIFO was full.
// Each requester feeds its own FIFO. A rotating-priority scan starting at
// rr_ptr grants up to two eligible heads per cycle; heads with dest==0 are
// dropped without using a port or moving the pointer.
module prf_wb_arbiter
  import prf_wb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int PREG_WIDTH = 7,
  parameter int FIFO_DEPTH = 2
) (
  input  logic    clk,
  input  logic    reset,
  input  logic    flush,
  prf_wb_if.slave bus
`ifdef PRF_WB_ARB_STALL_CNT_EN
  ,
  output logic [31:0] alu_stall_cnt,
  output logic [31:0] br_stall_cnt,
  output logic [31:0] lsu_stall_cnt
`endif
);

  typedef struct packed {
    logic [PREG_WIDTH-1:0] dest;
    logic [DATA_WIDTH-1:0] data;
  } req_t;

  logic [NUM_REQ-1:0] req_valid;
  logic [NUM_REQ-1:0] req_ready;
  logic [NUM_REQ-1:0] fifo_push;
  logic [NUM_REQ-1:0] fifo_pop;
  logic [NUM_REQ-1:0] fifo_full;
  logic [NUM_REQ-1:0] fifo_empty;
  logic [NUM_REQ-1:0] eligible;
  req_t               req_in   [NUM_REQ];
  req_t               fifo_head[NUM_REQ];

  req_idx_t rr_ptr_reg;
  req_idx_t rr_ptr_next;

  logic                  g0_found;
  logic                  g1_found;
  req_idx_t              g0_idx;
  req_idx_t              g1_idx;

  logic                  wb0_valid_reg;
  logic [PREG_WIDTH-1:0] wb0_dest_reg;
  logic [DATA_WIDTH-1:0] wb0_data_reg;
  logic                  wb1_valid_reg;
  logic [PREG_WIDTH-1:0] wb1_dest_reg;
  logic [DATA_WIDTH-1:0] wb1_data_reg;

  // Map the named interface signals onto index-ordered arrays.
  assign req_valid[REQ_ALU] = bus.alu_valid;
  assign req_valid[REQ_BR]  = bus.br_valid;
  assign req_valid[REQ_LSU] = bus.lsu_valid;

  assign req_in[REQ_ALU] = '{dest: bus.alu_dest, data: bus.alu_data};
  assign req_in[REQ_BR]  = '{dest: bus.br_dest,  data: bus.br_data};
  assign req_in[REQ_LSU] = '{dest: bus.lsu_dest, data: bus.lsu_data};

  assign bus.alu_ready = req_ready[REQ_ALU];
  assign bus.br_ready  = req_ready[REQ_BR];
  assign bus.lsu_ready = req_ready[REQ_LSU];

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
      // Ready depends only on registered occupancy and flush, never on valid.
      assign req_ready[gi] = !fifo_full[gi] && !flush;
      assign fifo_push[gi] = req_valid[gi] && req_ready[gi];
      assign eligible[gi]  = !fifo_empty[gi] && (fifo_head[gi].dest != '0);

      // A head leaves either because it was granted a port or because it
      // targets preg 0 and is simply discarded.
      assign fifo_pop[gi] = !fifo_empty[gi] && !flush &&
                            ((fifo_head[gi].dest == '0) ||
                             (g0_found && (g0_idx == req_idx_t'(gi))) ||
                             (g1_found && (g1_idx == req_idx_t'(gi))));

      wb_req_fifo #(
        .DEPTH (FIFO_DEPTH),
        .T     (req_t)
      ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .clear     (flush),
        .push      (fifo_push[gi]),
        .push_data (req_in[gi]),
        .pop       (fifo_pop[gi]),
        .head      (fifo_head[gi]),
        .full      (fifo_full[gi]),
        .empty     (fifo_empty[gi])
      );
    end
  endgenerate

  // Rotating scan from rr_ptr: first eligible head -> port 0, second -> port 1.
  always_comb begin
    req_idx_t scan_idx;
    g0_found = 1'b0;
    g1_found = 1'b0;
    g0_idx   = '0;
    g1_idx   = '0;
    scan_idx = rr_ptr_reg;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (eligible[scan_idx]) begin
        if (!g0_found) begin
          g0_found = 1'b1;
          g0_idx   = scan_idx;
        end else if (!g1_found) begin
          g1_found = 1'b1;
          g1_idx   = scan_idx;
        end
      end
      scan_idx = req_idx_inc(scan_idx);
    end
  end

  // The pointer moves just past the last requester that got a port.
  always_comb begin
    rr_ptr_next = rr_ptr_reg;
    if (g1_found)      rr_ptr_next = req_idx_inc(g1_idx);
    else if (g0_found) rr_ptr_next = req_idx_inc(g0_idx);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_reg    <= '0;
      wb0_valid_reg <= 1'b0;
      wb0_dest_reg  <= '0;
      wb0_data_reg  <= '0;
      wb1_valid_reg <= 1'b0;
      wb1_dest_reg  <= '0;
      wb1_data_reg  <= '0;
    end else if (flush) begin
      // Nothing is granted on a flush edge; the pointer keeps its value.
      wb0_valid_reg <= 1'b0;
      wb1_valid_reg <= 1'b0;
    end else begin
      rr_ptr_reg    <= rr_ptr_next;
      wb0_valid_reg <= g0_found;
      wb1_valid_reg <= g1_found;
      if (g0_found) begin
        wb0_dest_reg <= fifo_head[g0_idx].dest;
        wb0_data_reg <= fifo_head[g0_idx].data;
      end
      if (g1_found) begin
        wb1_dest_reg <= fifo_head[g1_idx].dest;
        wb1_data_reg <= fifo_head[g1_idx].data;
      end
    end
  end

  assign bus.wb0_valid = wb0_valid_reg;
  assign bus.wb0_dest  = wb0_dest_reg;
  assign bus.wb0_data  = wb0_data_reg;
  assign bus.wb1_valid = wb1_valid_reg;
  assign bus.wb1_dest  = wb1_dest_reg;
  assign bus.wb1_data  = wb1_data_reg;

`ifdef PRF_WB_ARB_STALL_CNT_EN
  logic [31:0] stall_cnt_reg [NUM_REQ];

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_stall
      // Flush cycles are not stalls even though ready is low.
      always_ff @(posedge clk) begin
        if (reset) begin
          stall_cnt_reg[gi] <= '0;
        end else if (req_valid[gi] && !req_ready[gi] && !flush &&
                     (stall_cnt_reg[gi] != 32'hFFFF_FFFF)) begin
          stall_cnt_reg[gi] <= stall_cnt_reg[gi] + 32'd1;
        end
      end
    end
  endgenerate

  assign alu_stall_cnt = stall_cnt_reg[REQ_ALU];
  assign br_stall_cnt  = stall_cnt_reg[REQ_BR];
  assign lsu_stall_cnt = stall_cnt_reg[REQ_LSU];
`endif

endmodule

// File: tb/tb_prf_wb_arbiter.sv
// tb_prf_wb_arbiter: directed and randomized stimulus against a queue-based
// reference model of the write-back arbiter.
module tb_prf_wb_arbiter;
  import prf_wb_pkg::*;

  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic reset;
  logic flush;

  always #5 clk = ~clk;

  prf_wb_if #(.DATA_WIDTH(32), .PREG_WIDTH(7)) bus ();

`ifdef PRF_WB_ARB_STALL_CNT_EN
  logic [31:0] alu_stall_cnt, br_stall_cnt, lsu_stall_cnt;
`endif

  prf_wb_arbiter #(
    .DATA_WIDTH (32),
    .PREG_WIDTH (7),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .bus   (bus)
`ifdef PRF_WB_ARB_STALL_CNT_EN
    ,
    .alu_stall_cnt (alu_stall_cnt),
    .br_stall_cnt  (br_stall_cnt),
    .lsu_stall_cnt (lsu_stall_cnt)
`endif
  );

  typedef struct {
    logic [6:0]  dest;
    logic [31:0] data;
  } ent_t;

  // Reference model state
  ent_t        mq [3][$];
  int          rr;
  logic        e0v, e1v;
  logic [6:0]  e0d, e1d;
  logic [31:0] e0x, e1x;
  longint      scnt [3];

  // Stimulus
  logic        drv_v [3];
  logic [6:0]  drv_d [3];
  logic [31:0] drv_x [3];

  int   n_checks;
  int   n_fail;
  logic lsu_seen;
  string names [3] = '{"alu", "br", "lsu"};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    for (int i = 0; i < 3; i++) begin
      drv_v[i] = 1'b0;
      drv_d[i] = '0;
      drv_x[i] = '0;
    end
  endtask

  task automatic set_req(input int i, input logic v, input logic [6:0] d, input logic [31:0] x);
    drv_v[i] = v;
    drv_d[i] = d;
    drv_x[i] = x;
  endtask

  task automatic apply_inputs();
    bus.alu_valid = drv_v[0]; bus.alu_dest = drv_d[0]; bus.alu_data = drv_x[0];
    bus.br_valid  = drv_v[1]; bus.br_dest  = drv_d[1]; bus.br_data  = drv_x[1];
    bus.lsu_valid = drv_v[2]; bus.lsu_dest = drv_d[2]; bus.lsu_data = drv_x[2];
  endtask

  function automatic logic dut_ready(input int i);
    case (i)
      0:       return bus.alu_ready;
      1:       return bus.br_ready;
      default: return bus.lsu_ready;
    endcase
  endfunction

  // One clock: check readys, advance the model, cross the edge, check ports.
  task automatic tick();
    int   order[$];
    int   ng;
    logic full_pre [3];
    logic was_rst;
    logic granted;
    apply_inputs();
    #1;
    was_rst = reset;
    for (int i = 0; i < 3; i++) full_pre[i] = (mq[i].size() >= DEPTH);
    if (!reset) begin
      for (int i = 0; i < 3; i++)
        chk({names[i], "_ready"}, 64'(dut_ready(i)), 64'(!full_pre[i] && !flush));
    end

    if (reset) begin
      for (int i = 0; i < 3; i++) mq[i].delete();
      rr = 0;
      e0v = 0; e0d = 0; e0x = 0;
      e1v = 0; e1d = 0; e1x = 0;
    end else if (flush) begin
      for (int i = 0; i < 3; i++) mq[i].delete();
      e0v = 0;
      e1v = 0;
    end else begin
      for (int k = 0; k < 3; k++) begin
        int i;
        i = (rr + k) % 3;
        if (mq[i].size() > 0 && mq[i][0].dest != 0) order.push_back(i);
      end
      ng  = (order.size() > 2) ? 2 : order.size();
      e0v = (ng > 0);
      e1v = (ng > 1);
      if (e0v) begin e0d = mq[order[0]][0].dest; e0x = mq[order[0]][0].data; end
      if (e1v) begin e1d = mq[order[1]][0].dest; e1x = mq[order[1]][0].data; end
      if (ng > 0) rr = (order[ng-1] + 1) % 3;
      for (int i = 0; i < 3; i++) begin
        if (mq[i].size() > 0) begin
          granted = (ng > 0 && order[0] == i) || (ng > 1 && order[1] == i);
          if (mq[i][0].dest == 0 || granted) void'(mq[i].pop_front());
        end
      end
      for (int i = 0; i < 3; i++)
        if (drv_v[i] && !full_pre[i]) mq[i].push_back('{dest: drv_d[i], data: drv_x[i]});
    end

    for (int i = 0; i < 3; i++) begin
      if (reset) scnt[i] = 0;
      else if (drv_v[i] && full_pre[i] && !flush && scnt[i] < 64'hFFFF_FFFF) scnt[i]++;
    end

    @(posedge clk);
    #1;
    chk("wb0_valid", 64'(bus.wb0_valid), 64'(e0v));
    chk("wb1_valid", 64'(bus.wb1_valid), 64'(e1v));
    if (e0v || was_rst) begin
      chk("wb0_dest", 64'(bus.wb0_dest), 64'(e0d));
      chk("wb0_data", 64'(bus.wb0_data), 64'(e0x));
    end
    if (e1v || was_rst) begin
      chk("wb1_dest", 64'(bus.wb1_dest), 64'(e1d));
      chk("wb1_data", 64'(bus.wb1_data), 64'(e1x));
    end
`ifdef PRF_WB_ARB_STALL_CNT_EN
    chk("alu_stall_cnt", 64'(alu_stall_cnt), 64'(scnt[0]));
    chk("br_stall_cnt",  64'(br_stall_cnt),  64'(scnt[1]));
    chk("lsu_stall_cnt", 64'(lsu_stall_cnt), 64'(scnt[2]));
`endif
    if ((bus.wb0_valid && bus.wb0_dest == 7'd20) || (bus.wb1_valid && bus.wb1_dest == 7'd20))
      lsu_seen = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rr       = 0;
    e0v = 0; e1v = 0; e0d = 0; e1d = 0; e0x = 0; e1x = 0;
    for (int i = 0; i < 3; i++) scnt[i] = 0;
    lsu_seen = 1'b0;
    reset = 1'b1;
    flush = 1'b0;
    idle();
    apply_inputs();
    @(negedge clk);

    // Reset state
    tick();
    tick();
    reset = 1'b0;
    tick();
    $display("reset: readys and write ports checked");

    // Single ALU result, two-edge latency
    set_req(0, 1'b1, 7'd5, 32'hDEAD_BEEF);
    tick();
    idle();
    tick();
    chk("lat_wb0_valid", 64'(bus.wb0_valid), 64'd1);
    chk("lat_wb0_dest",  64'(bus.wb0_dest),  64'd5);
    chk("lat_wb0_data",  64'(bus.wb0_data),  64'hDEAD_BEEF);
    chk("lat_wb1_valid", 64'(bus.wb1_valid), 64'd0);
    tick();
    chk("lat_pulse", 64'(bus.wb0_valid), 64'd0);
    $display("alu single push: dest=5 data=deadbeef");

    // All three at once from rr_ptr=0
    reset = 1'b1;
    tick();
    reset = 1'b0;
    set_req(0, 1'b1, 7'd1, 32'h1111_0001);
    set_req(1, 1'b1, 7'd2, 32'h2222_0002);
    set_req(2, 1'b1, 7'd3, 32'h3333_0003);
    tick();
    idle();
    tick();
    chk("tri_wb0_dest", 64'(bus.wb0_dest), 64'd1);
    chk("tri_wb1_dest", 64'(bus.wb1_dest), 64'd2);
    tick();
    chk("tri_wb0_dest2",  64'(bus.wb0_dest),  64'd3);
    chk("tri_wb1_valid2", 64'(bus.wb1_valid), 64'd0);
    tick();
    $display("three-way push: d1,d2 then d3");

    // Fairness under continuous ALU/BR traffic
    lsu_seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      set_req(0, 1'b1, 7'(10 + c), 32'hA000_0000 + c);
      set_req(1, 1'b1, 7'(40 + c), 32'hB000_0000 + c);
      set_req(2, 1'b1, 7'd20,      32'hC000_0000 + c);
      tick();
      if (c == 3) chk("lsu_fair", 64'(lsu_seen), 64'd1);
    end
    idle();
    repeat (6) tick();
    $display("fairness: lsu granted under contention");

    // dest==0 never reaches a port
    set_req(1, 1'b1, 7'd0, 32'h0000_1234);
    tick();
    idle();
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("dz_wb0_valid", 64'(bus.wb0_valid), 64'd0);
      chk("dz_wb1_valid", 64'(bus.wb1_valid), 64'd0);
    end
    set_req(1, 1'b1, 7'd9, 32'h0000_9999);
    tick();
    idle();
    repeat (3) tick();
    $display("dest zero: dropped silently");

    // Fill, then flush with ALU valid
    for (int c = 0; c < 6; c++) begin
      for (int i = 0; i < 3; i++) set_req(i, 1'b1, 7'(60 + 3 * c + i), 32'hF000_0000 + 3 * c + i);
      tick();
    end
    idle();
    set_req(0, 1'b1, 7'd77, 32'h7777_7777);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    idle();
    chk("fl_wb0_valid", 64'(bus.wb0_valid), 64'd0);
    chk("fl_wb1_valid", 64'(bus.wb1_valid), 64'd0);
    repeat (4) tick();
    $display("flush: buffered results dropped");

    // Randomized traffic with occasional flush and one mid-run reset
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 3; i++) begin
        drv_v[i] = ($urandom_range(0, 99) < 60);
        drv_d[i] = ($urandom_range(0, 7) == 0) ? 7'd0 : 7'($urandom_range(1, 127));
        drv_x[i] = $urandom;
      end
      flush = ($urandom_range(0, 39) == 0);
      reset = (c == 250);
      tick();
    end
    flush = 1'b0;
    reset = 1'b0;
    idle();
    repeat (4) tick();
    $display("random: 400 cycles against model");

`ifdef PRF_WB_ARB_STALL_CNT_EN
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int c = 0; c < 12; c++) begin
      for (int i = 0; i < 3; i++) set_req(i, 1'b1, 7'(1 + i), 32'h5000_0000 + c);
      tick();
    end
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("stall_clr", 64'(alu_stall_cnt), 64'd0);
    $display("stall counters: counted and cleared");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
